// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: PC source encodings, opcode/func constants,
// fetch FSM states and reset/bubble defaults.
package mips_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'd0;
  localparam logic [1:0] PCSRC_BR  = 2'd1;
  localparam logic [1:0] PCSRC_JMP = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUF  = 2'd2
  } fetch_state_t;

  // J-type target: upper nibble of the delay-slot PC, 26-bit word index.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [25:0] jaddr);
    return {pc_plus4[31:28], jaddr, 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched word, insert a bubble, or hold.
// One-cycle latency; hold is the default when neither load nor bubble is asserted.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  output logic        nop_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        nop_q, nop_d;

  // A bubble leaves pcPlus4 untouched so a jump in ID keeps a sane upper nibble.
  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    nop_d      = nop_q;
    if (bubble_i) begin
      instr_d = NOP_INSTR;
      nop_d   = 1'b1;
    end else if (load_i) begin
      instr_d    = instr_i;
      pc_plus4_d = pc_plus4_i;
      nop_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= 32'h0000_0000;
      nop_q      <= 1'b1;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      nop_q      <= nop_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus4_o = pc_plus4_q;
  assign nop_o      = nop_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, memory request FSM, stall buffer and deferred redirect.
// One word per cycle with zero-wait memory; stall freezes PC and IF/ID, buffering a returned word.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  PCsrc,
  input  logic [31:0] branchTarget,
  input  logic [25:0] jumpAddr,
  input  logic        stall,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  output logic [31:0] instr,
  output logic [31:0] pcPlus4,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic        nopOut
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  buf_q, buf_d;
  logic         pend_vld_q, pend_vld_d;
  logic [31:0]  pend_tgt_q, pend_tgt_d;

  logic        redir;
  logic [31:0] redir_tgt;
  logic [31:0] pc_inc;
  logic        ifid_load, ifid_bubble;
  logic [31:0] ifid_instr;

  assign redir     = !stall && (PCsrc == PCSRC_BR || PCsrc == PCSRC_JMP);
  assign redir_tgt = (PCsrc == PCSRC_BR) ? branchTarget : jump_target(pcPlus4, jumpAddr);
  assign pc_inc    = pc_q + 32'd4;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_d       = buf_q;
    pend_vld_d  = pend_vld_q;
    pend_tgt_d  = pend_tgt_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    unique case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (stall) begin
          // A word fetched for a pending redirect is junk: drop it and re-request.
          if (imemReady && !pend_vld_q) begin
            buf_d   = imemData;
            state_d = ST_BUF;
          end
        end else if (imemReady) begin
          ifid_bubble = redir || pend_vld_q;
          ifid_load   = !(redir || pend_vld_q);
          pend_vld_d  = 1'b0;
          if (redir)           pc_d = redir_tgt;
          else if (pend_vld_q) pc_d = pend_tgt_q;
          else                 pc_d = pc_inc;
        end else begin
          ifid_bubble = 1'b1;
          if (redir) begin
            pend_vld_d = 1'b1;
            pend_tgt_d = redir_tgt;
          end
        end
      end
      ST_BUF: begin
        if (!stall) begin
          state_d     = ST_REQ;
          ifid_bubble = redir;
          ifid_load   = !redir;
          pc_d        = redir ? redir_tgt : pc_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      buf_q      <= 32'h0000_0000;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_q      <= buf_d;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign ifid_instr = (state_q == ST_BUF) ? buf_q : imemData;

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .load_i    (ifid_load),
    .bubble_i  (ifid_bubble),
    .instr_i   (ifid_instr),
    .pc_plus4_i(pc_inc),
    .instr_o   (instr),
    .pc_plus4_o(pcPlus4),
    .nop_o     (nopOut)
  );

  assign imemReq  = (state_q == ST_REQ);
  assign imemAddr = pc_q;
  assign opcode   = instr[31:26];
  assign func     = instr[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded bench for fetch_stage: each accepted word is queued as {instr, pcPlus4}
// and retired when IF/ID shows a non-bubble update.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  PCsrc;
  logic [31:0] branchTarget;
  logic [25:0] jumpAddr;
  logic        stall;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemData;
  logic [31:0] instr;
  logic [31:0] pcPlus4;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic        nopOut;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a * 32'd7 + 32'h1234_5671;
  endfunction

  // Instruction memory: returns the word at the requested address whenever ready.
  assign imemData = word_at(imemAddr);

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .PCsrc       (PCsrc),
    .branchTarget(branchTarget),
    .jumpAddr    (jumpAddr),
    .stall       (stall),
    .imemReq     (imemReq),
    .imemAddr    (imemAddr),
    .imemReady   (imemReady),
    .imemData    (imemData),
    .instr       (instr),
    .pcPlus4     (pcPlus4),
    .opcode      (opcode),
    .func        (func),
    .nopOut      (nopOut)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] addr);
    sb.push_back({word_at(addr), addr + 32'd4});
  endtask

  // Advance one clock; retire a scoreboard entry if IF/ID was free to load a real word.
  task automatic tick();
    logic        stall_e, rst_e;
    logic [63:0] exp;
    @(posedge clk);
    stall_e = stall;
    rst_e   = rst;
    #1;
    if (rst_e && !stall_e && !nopOut) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected_word_nop", {31'd0, nopOut}, 32'd1);
      end else begin
        exp = sb.pop_front();
        check_eq("sb_instr", instr, exp[63:32]);
        check_eq("sb_pcplus4", pcPlus4, exp[31:0]);
        check_eq("sb_opcode", {26'd0, opcode}, {26'd0, exp[63:58]});
        check_eq("sb_func", {26'd0, func}, {26'd0, exp[37:32]});
      end
    end
  endtask

  task automatic drive(input logic [1:0] src, input logic [31:0] bt, input logic [25:0] ja,
                       input logic stl, input logic rdy);
    PCsrc        = src;
    branchTarget = bt;
    jumpAddr     = ja;
    stall        = stl;
    imemReady    = rdy;
  endtask

  task automatic check_bubble(input string tag, input logic [31:0] addr);
    check_eq({tag, "_nop"}, {31'd0, nopOut}, 32'd1);
    check_eq({tag, "_instr"}, instr, NOP);
    check_eq({tag, "_addr"}, imemAddr, addr);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_instr"}, instr, NOP);
    check_eq({tag, "_pc4"}, pcPlus4, 32'd0);
    check_eq({tag, "_nop"}, {31'd0, nopOut}, 32'd1);
    check_eq({tag, "_req"}, {31'd0, imemReq}, 32'd0);
    check_eq({tag, "_addr"}, imemAddr, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    drive(2'd0, 32'd0, 26'd0, 1'b0, 1'b1);
    tick();
    tick();
    check_reset("reset");

    // Back-to-back issue with zero-wait memory.
    rst = 1'b1;
    tick();
    check_eq("idle_to_req", {31'd0, imemReq}, 32'd1);
    check_eq("first_addr", imemAddr, 32'd0);
    push_word(32'd0);
    push_word(32'd4);
    push_word(32'd8);
    for (int i = 0; i < 3; i++) tick();
    check_eq("stream_addr", imemAddr, 32'd12);

    // Branch back to 8, then three wait cycles there.
    drive(2'd1, 32'd8, 26'd0, 1'b0, 1'b1);
    tick();
    check_bubble("br_to_8", 32'd8);
    drive(2'd0, 32'd0, 26'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_bubble("wait_at_8", 32'd8);
      check_eq("wait_req", {31'd0, imemReq}, 32'd1);
    end
    imemReady = 1'b1;
    push_word(32'd8);
    tick();
    check_eq("after_wait_addr", imemAddr, 32'd12);

    // Stall while the word at 12 returns: buffered, then released.
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("stall_instr", instr, word_at(32'd8));
      check_eq("stall_pc4", pcPlus4, 32'd12);
      check_eq("stall_addr", imemAddr, 32'd12);
      check_eq("stall_buf_noreq", {31'd0, imemReq}, 32'd0);
    end
    drive(2'd0, 32'd0, 26'd0, 1'b0, 1'b0);
    push_word(32'd12);
    tick();
    check_eq("unstall_addr", imemAddr, 32'd16);
    check_eq("unstall_req", {31'd0, imemReq}, 32'd1);

    // Branch, then build pcPlus4=0x1000_0010 and jump.
    drive(2'd1, 32'h40, 26'd0, 1'b0, 1'b1);
    tick();
    check_bubble("br_40", 32'h40);
    drive(2'd1, 32'h1000_000C, 26'd0, 1'b0, 1'b1);
    tick();
    check_bubble("br_hi", 32'h1000_000C);
    drive(2'd0, 32'd0, 26'd0, 1'b0, 1'b1);
    push_word(32'h1000_000C);
    tick();
    drive(2'd2, 32'd0, 26'h10, 1'b0, 1'b1);
    tick();
    check_bubble("jump", 32'h1000_0040);

    // Jump while memory is busy: deferred until the outstanding word returns.
    drive(2'd2, 32'd0, 26'h20, 1'b0, 1'b0);
    tick();
    check_bubble("pend_jmp", 32'h1000_0040);
    drive(2'd0, 32'd0, 26'd0, 1'b0, 1'b0);
    tick();
    check_bubble("pend_wait", 32'h1000_0040);
    imemReady = 1'b1;
    tick();
    check_bubble("pend_retire", 32'h1000_0080);

    // A later redirect before ready overwrites the pending target.
    drive(2'd1, 32'h300, 26'd0, 1'b0, 1'b0);
    tick();
    drive(2'd1, 32'h400, 26'd0, 1'b0, 1'b0);
    tick();
    check_bubble("pend_hold", 32'h1000_0080);
    drive(2'd0, 32'd0, 26'd0, 1'b0, 1'b1);
    tick();
    check_bubble("pend_overwrite", 32'h400);

    // Reset in the middle of an outstanding request.
    imemReady = 1'b0;
    rst = 1'b0;
    tick();
    check_reset("mid_reset");
    rst = 1'b1;
    imemReady = 1'b1;
    tick();
    check_eq("post_reset_nop", {31'd0, nopOut}, 32'd1);
    check_eq("post_reset_req", {31'd0, imemReq}, 32'd1);
    push_word(32'd0);
    tick();

    // PC wraps past the top of the address space.
    drive(2'd1, 32'hFFFF_FFFC, 26'd0, 1'b0, 1'b1);
    tick();
    check_bubble("br_top", 32'hFFFF_FFFC);
    drive(2'd0, 32'd0, 26'd0, 1'b0, 1'b1);
    push_word(32'hFFFF_FFFC);
    tick();
    check_eq("wrap_addr", imemAddr, 32'd0);

    // PCsrc=3 behaves as sequential.
    drive(2'd3, 32'h80, 26'h3F, 1'b0, 1'b1);
    push_word(32'd0);
    tick();
    check_eq("pcsrc3_addr", imemAddr, 32'd4);
    check_eq("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
